// File: rtl/smc_sioc_clk_gen_if.sv
// Signal bundle between the SCCB master FSM and the SIO_C timing generator.
// The FSM side is the master; the generator is the slave.
interface smc_sioc_clk_gen_if #(
    parameter int CNT_W = 16,
    parameter int BIT_W = 4
);
    logic             cntr_en_i;
    logic [CNT_W-1:0] hcyc_i;
    logic             sioc_o;
    logic             sioc_fall_o;
    logic             sioc_rise_o;
    logic             tick_en_o;
    logic             sample_en_o;
    logic [BIT_W-1:0] bit_idx_o;
    logic             phase_done_o;
    logic             busy_o;

    modport master (
        output cntr_en_i, hcyc_i,
        input  sioc_o, sioc_fall_o, sioc_rise_o, tick_en_o, sample_en_o,
               bit_idx_o, phase_done_o, busy_o
    );

    modport slave (
        input  cntr_en_i, hcyc_i,
        output sioc_o, sioc_fall_o, sioc_rise_o, tick_en_o, sample_en_o,
               bit_idx_o, phase_done_o, busy_o
    );
endinterface

// File: rtl/smc_sioc_clk_gen.sv
// SIO_C generator: run-time half period latched at start, mid-low/mid-high ticks,
// per-phase bit counting, and a stop path that always parks SIO_C high.
module smc_sioc_clk_gen #(
    parameter int CNT_W          = 16,
    parameter int MIN_HCYC       = 4,
    parameter int BITS_PER_PHASE = 9,
    parameter int BIT_W          = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    smc_sioc_clk_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [CNT_W-1:0] MIN_V    = CNT_W'(MIN_HCYC);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BITS_PER_PHASE - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, hcyc_eff, hcyc_clamp;
    logic [BIT_W-1:0] bit_idx;
    logic             sioc;
    logic             end_hc, mid, last_bit;
    logic             fall, rise, tick, sample, done;

    assign hcyc_clamp = (bus.hcyc_i < MIN_V) ? MIN_V : bus.hcyc_i;
    assign end_hc     = (cnt == hcyc_eff - CNT_W'(1));
    assign mid        = (cnt == (hcyc_eff >> 1));
    assign last_bit   = (bit_idx == LAST_BIT);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.cntr_en_i) state_nxt = RUN;
            // Dropping the run request mid-low must finish the low half first.
            RUN:   if (!bus.cntr_en_i) state_nxt = (sioc || end_hc) ? IDLE : DRAIN;
            DRAIN: if (end_hc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // High-half strobes are withheld when the run is being abandoned, so a
    // fall strobe always means SIO_C really falls.
    always_comb begin
        rise   = 1'b0;
        fall   = 1'b0;
        tick   = 1'b0;
        sample = 1'b0;
        done   = 1'b0;
        case (state)
            RUN: begin
                rise   = end_hc & ~sioc;
                fall   = end_hc & sioc & bus.cntr_en_i;
                tick   = mid & ~sioc;
                sample = mid & sioc & bus.cntr_en_i;
                done   = end_hc & sioc & bus.cntr_en_i & last_bit;
            end
            DRAIN: rise = end_hc;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            bit_idx  <= '0;
            hcyc_eff <= MIN_V;
            sioc     <= 1'b1;
        end else begin
            case (state)
                RUN, DRAIN: begin
                    if (state_nxt == IDLE) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        sioc    <= 1'b1;
                    end else if (end_hc) begin
                        cnt  <= '0;
                        sioc <= ~sioc;
                        if (fall) bit_idx <= last_bit ? '0 : bit_idx + BIT_W'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    sioc    <= 1'b1;
                    if (bus.cntr_en_i) begin
                        hcyc_eff <= hcyc_clamp;
                        sioc     <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.sioc_o       = sioc;
    assign bus.sioc_fall_o  = fall;
    assign bus.sioc_rise_o  = rise;
    assign bus.tick_en_o    = tick;
    assign bus.sample_en_o  = sample;
    assign bus.bit_idx_o    = bit_idx;
    assign bus.phase_done_o = done;
    assign bus.busy_o       = (state != IDLE);
endmodule

// File: tb/tb_smc_sioc_clk_gen.sv
// Directed bench for smc_sioc_clk_gen: start latency, waveform, phase wrap,
// clamp, drain, high-half stop and mid-run reset.
module tb_smc_sioc_clk_gen;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    smc_sioc_clk_gen_if #(.CNT_W(16), .BIT_W(4)) bus ();

    smc_sioc_clk_gen #(
        .CNT_W(16), .MIN_HCYC(4), .BITS_PER_PHASE(9), .BIT_W(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // p = cycle position within one SIO_C period, h = effective half period
    task automatic chk_wave(input string tag, input int p, input int h);
        chk({tag, " sioc"},   32'(bus.sioc_o),      32'(p >= h));
        chk({tag, " tick"},   32'(bus.tick_en_o),   32'(p == h / 2));
        chk({tag, " rise"},   32'(bus.sioc_rise_o), 32'(p == h - 1));
        chk({tag, " sample"}, 32'(bus.sample_en_o), 32'(p == h + h / 2));
        chk({tag, " fall"},   32'(bus.sioc_fall_o), 32'(p == 2 * h - 1));
        chk({tag, " busy"},   32'(bus.busy_o),      32'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " sioc"},  32'(bus.sioc_o),       32'd1);
        chk({tag, " busy"},  32'(bus.busy_o),       32'd0);
        chk({tag, " bit"},   32'(bus.bit_idx_o),    32'd0);
        chk({tag, " rise"},  32'(bus.sioc_rise_o),  32'd0);
        chk({tag, " fall"},  32'(bus.sioc_fall_o),  32'd0);
        chk({tag, " tick"},  32'(bus.tick_en_o),    32'd0);
        chk({tag, " samp"},  32'(bus.sample_en_o),  32'd0);
        chk({tag, " done"},  32'(bus.phase_done_o), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.cntr_en_i = 1'b0;
        bus.hcyc_i    = 16'd10;
        step();
        step();
        chk_idle("reset");
        rst_n = 1'b1;
        step();
        chk_idle("idle");

        // Scenarios 1+2: hcyc=10, ten full periods across a phase wrap
        bus.cntr_en_i = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            step();
            chk_wave("run10", (i - 1) % 20, 10);
            chk("run10 bit",  32'(bus.bit_idx_o),    32'(((i - 1) / 20) % 9));
            chk("run10 done", 32'(bus.phase_done_o), 32'(i == 180));
        end

        // Scenario 4: drop the request at cnt=3 of a low half
        for (int i = 201; i <= 204; i++) begin
            step();
            chk_wave("pre_drain", (i - 1) % 20, 10);
        end
        bus.cntr_en_i = 1'b0;
        for (int i = 205; i <= 210; i++) begin
            step();
            chk("drain sioc", 32'(bus.sioc_o),       32'd0);
            chk("drain busy", 32'(bus.busy_o),       32'd1);
            chk("drain tick", 32'(bus.tick_en_o),    32'd0);
            chk("drain bit",  32'(bus.bit_idx_o),    32'd1);
            chk("drain rise", 32'(bus.sioc_rise_o),  32'(i == 210));
        end
        step();
        chk_idle("drained");

        // Scenario 3: hcyc below the minimum clamps to 4; mid-run change ignored
        bus.hcyc_i    = 16'd2;
        bus.cntr_en_i = 1'b1;
        for (int n = 1; n <= 21; n++) begin
            step();
            if (n == 3) bus.hcyc_i = 16'd20;
            chk_wave("clamp", (n - 1) % 8, 4);
            chk("clamp bit", 32'(bus.bit_idx_o), 32'((n - 1) / 8));
        end

        // Scenario 5: drop the request during a high half
        bus.cntr_en_i = 1'b0;
        step();
        chk_idle("hi_stop");

        // Restart picks up hcyc=20, then reset mid-low half
        bus.cntr_en_i = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            step();
            chk_wave("run20", n - 1, 20);
        end
        rst_n = 1'b0;
        step();
        chk_idle("mid_rst");

        // Scenario 6: release with the request still high restarts as scenario 1
        bus.hcyc_i = 16'd10;
        rst_n      = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            chk_wave("restart", i - 1, 10);
            chk("restart bit", 32'(bus.bit_idx_o), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
